// File: rtl/cpu_bus_if_pkg.sv
// Shared types and constants for the CPU external bus interface unit.
package cpu_bus_if_pkg;

  // Kind of machine cycle requested by the core.
  typedef enum logic [1:0] {
    BUS_NOP   = 2'd0,
    BUS_READ  = 2'd1,
    BUS_WRITE = 2'd2
  } bus_op_t;

  // One idle state plus the four T-states of an M-cycle.
  typedef enum logic [2:0] {
    IDLE,
    T1,
    T2,
    T3,
    T4
  } bus_state_t;

  // Read data returned when a cycle is aborted on wait timeout.
  localparam logic [7:0] BUS_ABORT_DATA = 8'hFF;

endpackage

// File: rtl/cpu_bus_if_if.sv
// Request/response channel from the core plus the external byte bus.
// The slave view is the bus interface unit; the master view is everything
// around it (the core on the request side and memory on the bus side).
interface cpu_bus_if_if;
  import cpu_bus_if_pkg::*;

  // Core request channel
  logic        req_valid;
  logic        req_ready;
  bus_op_t     req_op;
  logic [15:0] req_addr;
  logic [7:0]  req_wdata;

  // Completion response
  logic        rsp_valid;
  logic [7:0]  rsp_rdata;
  logic        rsp_err;

  // External memory bus
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        mem_rd;
  logic        mem_wr;
  logic        mem_ready;

  modport master (
    output req_valid, req_op, req_addr, req_wdata, mem_rdata, mem_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
           mem_addr, mem_wdata, mem_rd, mem_wr
  );

  modport slave (
    input  req_valid, req_op, req_addr, req_wdata, mem_rdata, mem_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
           mem_addr, mem_wdata, mem_rd, mem_wr
  );

endinterface

// File: rtl/cpu_bus_if_wait_timer.sv
// Wait-state counter for T3: counts clocks while memory is not ready and
// flags terminal count once the configured limit has been reached.
module cpu_bus_if_wait_timer (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr_i,
  input  logic       en_i,
  input  logic [7:0] limit_i,
  output logic       tc_o
);

  logic [7:0] count_q;

  // Count wait clocks; clear has priority over enable.
  // NOTE: sequential state is always assigned with <= so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= 8'h00;
    end else if (clr_i) begin
      count_q <= 8'h00;
    end else if (en_i) begin
      count_q <= count_q + 8'd1;
    end
  end

  assign tc_o = (count_q == limit_i);

endmodule

// File: rtl/cpu_bus_if.sv
// Bus interface unit: runs one T1-T4 machine cycle per accepted core
// request on the external byte bus, stretches T3 while memory is not ready,
// aborts after WAIT_MAX wait clocks and pulses a response in T4.
module cpu_bus_if
  import cpu_bus_if_pkg::*;
#(
  parameter int unsigned WAIT_MAX = 15
) (
  input logic         clk,
  input logic         rst,
  cpu_bus_if_if.slave bus
);

  bus_state_t  state_q, state_d;
  bus_op_t     op_q, op_d;
  logic [15:0] addr_q;
  logic [7:0]  wdata_q;
  logic [7:0]  rdata_q, rdata_d;
  logic        req_ready_q;
  logic        rsp_valid_q;
  logic        rsp_err_q;
  logic        mem_rd_q;
  logic        mem_wr_q;

  logic        accept;
  logic        abort;
  logic        tmr_clr;
  logic        tmr_en;
  logic        tmr_tc;

  // req_ready_q is high exactly in IDLE and T4, so accept never depends
  // combinationally on anything but the registered state and req_valid.
  assign accept = bus.req_valid && req_ready_q;

  // The counter only runs across consecutive not-ready T3 clocks and stops
  // once the limit is reached so the abort decision sees a stable value.
  assign tmr_clr = (state_q != T3) || bus.mem_ready;
  assign tmr_en  = (state_q == T3) && !bus.mem_ready && !tmr_tc;

  cpu_bus_if_wait_timer u_wait_timer (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (tmr_clr),
    .en_i    (tmr_en),
    .limit_i (8'(WAIT_MAX)),
    .tc_o    (tmr_tc)
  );

  // Next-state, latched op and read-data decisions for the M-cycle.
  // NOTE: every variable gets a default before the case so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    rdata_d = rdata_q;
    abort   = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = T1;
          op_d    = bus.req_op;
        end
      end
      T1: state_d = T2;
      T2: state_d = T3;
      T3: begin
        if (bus.mem_ready) begin
          state_d = T4;
          if (op_q == BUS_READ) begin
            rdata_d = bus.mem_rdata;
          end
        end else if (tmr_tc) begin
          state_d = T4;
          abort   = 1'b1;
          if (op_q == BUS_READ) begin
            rdata_d = BUS_ABORT_DATA;
          end
        end
      end
      T4: begin
        if (accept) begin
          state_d = T1;
          op_d    = bus.req_op;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, request latch and registered outputs decoded from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      op_q        <= BUS_NOP;
      addr_q      <= 16'h0000;
      wdata_q     <= 8'h00;
      rdata_q     <= 8'h00;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      mem_rd_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      rdata_q <= rdata_d;
      if (accept) begin
        addr_q  <= bus.req_addr;
        wdata_q <= bus.req_wdata;
      end
      req_ready_q <= (state_d == IDLE) || (state_d == T4);
      rsp_valid_q <= (state_d == T4);
      rsp_err_q   <= abort;
      mem_rd_q    <= (op_d == BUS_READ)  && (state_d inside {T1, T2, T3});
      mem_wr_q    <= (op_d == BUS_WRITE) && (state_d inside {T2, T3});
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_rd    = mem_rd_q;
  assign bus.mem_wr    = mem_wr_q;

endmodule

// File: doc/cpu_bus_if.md
# cpu_bus_if

Bus interface unit that carries the CPU core's 16-bit address, as produced by the increment/decrement path, out to external memory. It is the responder on the core's memory request channel and runs one four-T-state machine cycle (T1–T4) per request on the external byte bus. It inserts wait states on a not-ready memory, aborts with an error after a bounded wait, and returns a one-cycle completion response at T4.

## Interface
Parameters:
- WAIT_MAX, 15: maximum wait-state clocks held in T3 before abort; legal range 1–255.

Ports:
- clk  in  1  core clock.
- rst  in  1  reset: asynchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request this cycle.
- req_op  in  bus_op_t  BUS_NOP, BUS_READ or BUS_WRITE.
- req_addr  in  16  byte address.
- req_wdata  in  8  write data.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  8  read data, or 8'hFF on abort.
- rsp_err  out  1  wait timeout; qualified by rsp_valid.
- mem_addr  out  16  external address.
- mem_wdata  out  8  external write data.
- mem_rdata  in  8  external read data.
- mem_rd  out  1  read strobe.
- mem_wr  out  1  write strobe.
- mem_ready  in  1  memory ready; sampled only in T3.

## Operation
- FSM states: IDLE, T1, T2, T3, T4. The strobes and req_ready are decoded from the registered state only; they never depend combinationally on req_valid.
- A request is accepted when req_valid and req_ready are both high. req_ready=1 in IDLE and in T4; it is 0 everywhere else.
- On accept: latch req_op, req_addr and req_wdata, drive mem_addr and mem_wdata from the latch, and go to T1.
- T1→T2→T3 unconditionally.
- mem_rd=1 in T1, T2 and T3 for BUS_READ.
- mem_wr=1 in T2 and T3 for BUS_WRITE.
- BUS_NOP produces no strobes but takes full M-cycle timing. It is used for internal-only M-cycles.
- T3 with mem_ready=1:
  - capture mem_rdata into rsp_rdata (reads only);
  - clear the wait counter;
  - go to T4.
- T3 with mem_ready=0:
  - stay in T3 and increment the wait counter;
  - when the counter equals WAIT_MAX, go to T4 with the abort flag set;
  - on abort, rsp_rdata is loaded with 8'hFF (reads only) and both strobes drop.
- T4:
  - rsp_valid=1 for exactly one clock;
  - rsp_err=1 on abort, otherwise 0;
  - a request accepted in T4 goes to T1, otherwise the FSM goes to IDLE.
- Writes and NOPs leave rsp_rdata unchanged.
- mem_addr and mem_wdata hold their last values while in IDLE.
- mem_ready is ignored outside T3.
- Reset values, asserted asynchronously: state=IDLE; req_ready=1; rsp_valid=0; rsp_err=0; rsp_rdata=8'h00; mem_addr=16'h0000; mem_wdata=8'h00; mem_rd=0; mem_wr=0; wait counter=0.
- Reset in the middle of a cycle discards the latched request, and no response is issued for it.

## Timing
- Accept in cycle N (IDLE) → T1 at N+1, T2 at N+2, T3 at N+3, T4 and rsp_valid at N+4, with no waits.
- Each wait adds exactly one clock. With k waits (k < WAIT_MAX), rsp_valid lands at N+4+k.
- Abort: rsp_valid lands at N+4+WAIT_MAX with rsp_err=1.
- Back-to-back: accepting in T4 gives a 4-clock M-cycle with no IDLE bubble. Throughput is one request per 4 clocks.
- Read data is sampled on the clock edge that leaves T3. It is stable from T4 until the next read capture.
- mem_addr changes only on the accept edge and is stable for the whole T1–T4 window.
- Request and response pulse in the same T4 cycle when back-to-back: the new request's latch and the old response do not interfere.

## Structure
- Shared cpu_pkg additions:
  - bus_op_t enum: BUS_NOP, BUS_READ, BUS_WRITE;
  - bus_state_t enum: IDLE, T1, T2, T3, T4;
  - constant BUS_ABORT_DATA = 8'hFF.
- One sub-module is natural: bus_wait_timer. It is an 8-bit counter with clear, enable and limit inputs, and its terminal-count output means the wait limit has been hit.

## Test plan
- Read 16'hC000 with mem_rdata=8'h5A and mem_ready=1 → mem_rd high in T1–T3; rsp_valid at N+4 with rsp_rdata=8'h5A and rsp_err=0.
- Write 8'h3C to 16'hFF80 → mem_wr high in T2–T3 only with mem_wdata=8'h3C and mem_addr=16'hFF80; rsp_valid at N+4; rsp_rdata unchanged.
- Read with mem_ready low for 3 T3 clocks, then high with 8'hA7 → rsp_valid at N+7 with rsp_rdata=8'hA7 and rsp_err=0.
- Read with mem_ready held low and WAIT_MAX=15 → rsp_valid at N+19 with rsp_err=1, rsp_rdata=8'hFF, and strobes low in T4.
- Back-to-back: read 16'h0100, NOP, then write 16'h0101, all presented continuously → responses at N+4, N+8 and N+12; NOP cycle has no strobes; req_ready is low outside IDLE and T4.
- Assert rst during the T2 of a read → outputs at reset values immediately; no rsp_valid; the next request after release is accepted from IDLE with normal latency.
